wb_stage: RTL and testbench



---
 rtl/wb_stage.sv | 168 ++++++++++++++++
 tb/tb_wb_stage.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// wb_stage: writeback stage in front of the architectural register file.
// It takes results from the ALU and from the LSU, formats the load data,
// picks one result per cycle and registers it onto the register-file
// write port. When an ALU result and an LSU result arrive in the same
// cycle, the ALU result waits in a one-entry hold buffer.
// Optional build macro WB_FORWARD_EN adds the fwd_valid_o, fwd_rd_o and
// fwd_data_o outputs. Decode uses them to bypass the value that is being
// written this cycle.
// write_params_o is packed as {write_enable, addr_rd}.
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif

module wb_stage #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = `REG_ADDR_WIDTH
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  // ALU result channel
  input  logic                     alu_valid_i,
  output logic                     alu_ready_o,
  input  logic [ADDR_W-1:0]        alu_rd_i,
  input  logic [XLEN-1:0]          alu_data_i,
  // LSU load result channel
  input  logic                     lsu_valid_i,
  output logic                     lsu_ready_o,
  input  logic [ADDR_W-1:0]        lsu_rd_i,
  input  logic [XLEN-1:0]          lsu_word_i,
  input  logic [2:0]               lsu_funct3_i,
  input  logic [1:0]               lsu_offset_i,
  // register file write port
  output logic [ADDR_W:0]          write_params_o,
  output logic [XLEN-1:0]          data_rd_o,
  // hazard detection
  output logic [(1<<ADDR_W)-1:0]   pending_mask_o
`ifdef WB_FORWARD_EN
  ,
  output logic                     fwd_valid_o,
  output logic [ADDR_W-1:0]        fwd_rd_o,
  output logic [XLEN-1:0]          fwd_data_o
`endif
);

  // RV32I load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // output register
  logic              out_v_q,    out_v_d;
  logic [ADDR_W-1:0] out_rd_q,   out_rd_d;
  logic [XLEN-1:0]   out_data_q, out_data_d;

  // one-entry ALU hold buffer
  logic              hold_v_q,    hold_v_d;
  logic [ADDR_W-1:0] hold_rd_q,   hold_rd_d;
  logic [XLEN-1:0]   hold_data_q, hold_data_d;

  logic [XLEN-1:0]   lsu_sh;
  logic [XLEN-1:0]   lsu_fmt;
  logic              write_en;
  logic [(1<<ADDR_W)-1:0] pend;

  // Ready depends only on state. An occupied hold entry owns the next
  // output slot, so neither source can be accepted while it is full.
  assign alu_ready_o = !hold_v_q;
  assign lsu_ready_o = !hold_v_q;

  // Load formatting: shift the addressed byte or halfword down to bit 0,
  // then extend it.
  assign lsu_sh = lsu_word_i >> {lsu_offset_i, 3'b000};

  // Extend the selected field according to the load type.
  // LH at offset 3 has only one byte left in the word. That byte is
  // sign-extended on its own. LHU at offset 3 zero-fills the missing byte.
  // LW and the reserved codes pass the word through unshifted.
  always_comb begin
    lsu_fmt = lsu_word_i;
    case (lsu_funct3_i)
      F3_LB:  lsu_fmt = {{(XLEN-8){lsu_sh[7]}}, lsu_sh[7:0]};
      F3_LH:  begin
        if (lsu_offset_i == 2'd3)
          lsu_fmt = {{(XLEN-8){lsu_sh[7]}}, lsu_sh[7:0]};
        else
          lsu_fmt = {{(XLEN-16){lsu_sh[15]}}, lsu_sh[15:0]};
      end
      F3_LBU: lsu_fmt = {{(XLEN-8){1'b0}}, lsu_sh[7:0]};
      F3_LHU: lsu_fmt = {{(XLEN-16){1'b0}}, lsu_sh[15:0]};
      default: lsu_fmt = lsu_word_i;
    endcase
  end

  // Select the next output. Priority is: held entry, then LSU, then ALU.
  // An ALU result that arrives with an LSU result goes into hold, unless
  // it targets x0. An x0 result is dropped here and costs no stall.
  always_comb begin
    out_v_d     = 1'b0;
    out_rd_d    = out_rd_q;
    out_data_d  = out_data_q;
    hold_v_d    = hold_v_q;
    hold_rd_d   = hold_rd_q;
    hold_data_d = hold_data_q;
    if (hold_v_q) begin
      out_v_d    = 1'b1;
      out_rd_d   = hold_rd_q;
      out_data_d = hold_data_q;
      hold_v_d   = 1'b0;
    end else if (lsu_valid_i) begin
      out_v_d    = 1'b1;
      out_rd_d   = lsu_rd_i;
      out_data_d = lsu_fmt;
      if (alu_valid_i && (alu_rd_i != '0)) begin
        hold_v_d    = 1'b1;
        hold_rd_d   = alu_rd_i;
        hold_data_d = alu_data_i;
      end
    end else if (alu_valid_i) begin
      out_v_d    = 1'b1;
      out_rd_d   = alu_rd_i;
      out_data_d = alu_data_i;
    end
  end

  // Register the output slot and the hold buffer. Reset discards both.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      out_v_q     <= 1'b0;
      out_rd_q    <= '0;
      out_data_q  <= '0;
      hold_v_q    <= 1'b0;
      hold_rd_q   <= '0;
      hold_data_q <= '0;
    end else begin
      out_v_q     <= out_v_d;
      out_rd_q    <= out_rd_d;
      out_data_q  <= out_data_d;
      hold_v_q    <= hold_v_d;
      hold_rd_q   <= hold_rd_d;
      hold_data_q <= hold_data_d;
    end
  end

  // A result for x0 is consumed but never written.
  assign write_en       = out_v_q && (out_rd_q != '0);
  assign write_params_o = {write_en, out_rd_q};
  assign data_rd_o      = out_data_q;

  // Decode the pending destinations from registered state only.
  // Bit 0 stays clear because x0 is never written.
  always_comb begin
    pend = '0;
    if (out_v_q)  pend[out_rd_q]  = 1'b1;
    if (hold_v_q) pend[hold_rd_q] = 1'b1;
    pend[0] = 1'b0;
  end

  assign pending_mask_o = pend;

`ifdef WB_FORWARD_EN
  // Bypass copy of the value being written this cycle.
  assign fwd_valid_o = write_en;
  assign fwd_rd_o    = out_rd_q;
  assign fwd_data_o  = out_data_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: scoreboard bench for wb_stage.
// The model is a queue of expected register writes. Each entry holds a
// destination, a value and the cycle in which the write must appear.
// The driver pushes entries when it issues stimulus. The monitor compares
// them against the write port and the pending mask.
`timescale 1ns/1ps

module tb_wb_stage;

  logic        clock, reset;
  logic        alu_valid, lsu_valid;
  logic        alu_ready, lsu_ready;
  logic [4:0]  alu_rd, lsu_rd;
  logic [31:0] alu_data, lsu_word;
  logic [2:0]  lsu_funct3;
  logic [1:0]  lsu_offset;
  logic [5:0]  write_params;
  logic [31:0] data_rd;
  logic [31:0] pending_mask;
`ifdef WB_FORWARD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
`endif

  wb_stage dut (
    .clock_i        (clock),
    .reset_i        (reset),
    .alu_valid_i    (alu_valid),
    .alu_ready_o    (alu_ready),
    .alu_rd_i       (alu_rd),
    .alu_data_i     (alu_data),
    .lsu_valid_i    (lsu_valid),
    .lsu_ready_o    (lsu_ready),
    .lsu_rd_i       (lsu_rd),
    .lsu_word_i     (lsu_word),
    .lsu_funct3_i   (lsu_funct3),
    .lsu_offset_i   (lsu_offset),
    .write_params_o (write_params),
    .data_rd_o      (data_rd),
    .pending_mask_o (pending_mask)
`ifdef WB_FORWARD_EN
    ,
    .fwd_valid_o    (fwd_valid),
    .fwd_rd_o       (fwd_rd),
    .fwd_data_o     (fwd_data)
`endif
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  logic rdy_m = 1'b1;
  logic mon_en = 1'b0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference load formatting, written from the RV32I load rules.
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] off);
    logic [31:0] s;
    logic [7:0]  b;
    logic [15:0] h;
    s = w >> (8 * off);
    b = s[7:0];
    h = s[15:0];
    case (f3)
      3'd0:    return {{24{b[7]}}, b};
      3'd1:    return (off == 2'd3) ? {{24{b[7]}}, b} : {{16{h[15]}}, h};
      3'd4:    return {24'h0, b};
      3'd5:    return {16'h0, h};
      default: return w;
    endcase
  endfunction

  // Monitor: compare the write port, pending mask and forward port with the queue.
  always @(negedge clock) begin
    if (mon_en) begin
      logic [31:0] m;
      m = '0;
      foreach (q[i]) m[q[i].rd] = 1'b1;
      chk("pending_mask", pending_mask, m);
`ifdef WB_FORWARD_EN
      chk("fwd_valid", {31'h0, fwd_valid}, {31'h0, write_params[5]});
      chk("fwd_rd", {27'h0, fwd_rd}, {27'h0, write_params[4:0]});
      chk("fwd_data", fwd_data, data_rd);
`endif
      if (write_params[5]) begin
        if (q.size() == 0) begin
          chk("unexpected_write_rd", {27'h0, write_params[4:0]}, 32'h0);
        end else begin
          chk("write_cycle", cyc, q[0].due);
          chk("write_rd", {27'h0, write_params[4:0]}, {27'h0, q[0].rd});
          chk("write_data", data_rd, q[0].data);
          void'(q.pop_front());
        end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        chk("missing_write_rd", 32'h0, {27'h0, q[0].rd});
        void'(q.pop_front());
      end
    end
  end

  // Drive one cycle of stimulus and record in the model what was accepted.
  task automatic step(input logic lv, input logic [4:0] lrd, input logic [31:0] lw,
                      input logic [2:0] f3, input logic [1:0] off, input logic [31:0] lexp,
                      input logic av, input logic [4:0] ard, input logic [31:0] ad);
    logic stall;
    lsu_valid = lv; lsu_rd = lrd; lsu_word = lw; lsu_funct3 = f3; lsu_offset = off;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    @(posedge clock); #1;
    stall = 1'b0;
    if (rdy_m) begin
      if (lv) begin
        if (lrd != 0) q.push_back('{rd: lrd, data: lexp, due: cyc});
        if (av && ard != 0) begin
          q.push_back('{rd: ard, data: ad, due: cyc + 1});
          stall = 1'b1;
        end
      end else if (av && ard != 0) begin
        q.push_back('{rd: ard, data: ad, due: cyc});
      end
    end
    rdy_m = !stall;
    chk("alu_ready", {31'h0, alu_ready}, {31'h0, rdy_m});
    chk("lsu_ready", {31'h0, lsu_ready}, {31'h0, rdy_m});
    lsu_valid = 1'b0;
    alu_valid = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'h0, 3'd2, 2'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  initial begin
    logic [31:0] w;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [4:0]  lrd, ard;
    reset = 1'b1;
    alu_valid = 0; lsu_valid = 0; alu_rd = 0; lsu_rd = 0;
    alu_data = 0; lsu_word = 0; lsu_funct3 = 0; lsu_offset = 0;
    repeat (3) @(posedge clock);
    @(negedge clock) reset = 1'b0;
    @(negedge clock);
    chk("rst_we", {31'h0, write_params[5]}, 32'h0);
    chk("rst_addr", {27'h0, write_params[4:0]}, 32'h0);
    chk("rst_data", data_rd, 32'h0);
    chk("rst_mask", pending_mask, 32'h0);
    chk("rst_ready", {30'h0, alu_ready, lsu_ready}, 32'h3);
    @(posedge clock); #1;
    mon_en = 1'b1;

    // Directed cases
    step(1'b0, 5'd0, 32'h0, 3'd2, 2'd0, 32'h0, 1'b1, 5'd5, 32'h1234);
    idle();
    w = 32'h80FF7F01;
    step(1'b1, 5'd10, w, 3'b000, 2'd1, 32'h0000007F, 1'b0, 5'd0, 32'h0);
    step(1'b1, 5'd11, w, 3'b000, 2'd3, 32'hFFFFFF80, 1'b0, 5'd0, 32'h0);
    step(1'b1, 5'd12, w, 3'b101, 2'd2, 32'h000080FF, 1'b0, 5'd0, 32'h0);
    step(1'b1, 5'd13, w, 3'b001, 2'd2, 32'hFFFF80FF, 1'b0, 5'd0, 32'h0);
    step(1'b1, 5'd14, w, 3'b010, 2'd0, 32'h80FF7F01, 1'b0, 5'd0, 32'h0);
    step(1'b1, 5'd15, w, 3'b001, 2'd3, 32'hFFFFFF80, 1'b0, 5'd0, 32'h0);
    step(1'b1, 5'd3, 32'hAAAA, 3'b010, 2'd0, 32'hAAAA, 1'b1, 5'd3, 32'hBBBB);
    idle();
    step(1'b0, 5'd0, 32'h0, 3'd2, 2'd0, 32'h0, 1'b1, 5'd0, 32'hDEAD);
    step(1'b1, 5'd4, 32'h44, 3'b010, 2'd0, 32'h44, 1'b1, 5'd0, 32'hDEAD);
    step(1'b1, 5'd6, 32'h66, 3'b010, 2'd0, 32'h66, 1'b1, 5'd6, 32'h77);
    step(1'b1, 5'd7, 32'h99, 3'b010, 2'd0, 32'h99, 1'b1, 5'd8, 32'h88);
    idle();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      w   = $urandom;
      f3  = 3'($urandom_range(0, 7));
      off = 2'($urandom_range(0, 3));
      lrd = 5'($urandom_range(0, 31));
      ard = ($urandom_range(0, 3) == 0) ? lrd : 5'($urandom_range(0, 31));
      step(1'($urandom_range(0, 1)), lrd, w, f3, off, ref_load(w, f3, off),
           1'($urandom_range(0, 1)), ard, $urandom);
    end
    repeat (4) idle();
    chk("drain", q.size(), 0);

    // Reset while the hold buffer is occupied
    step(1'b1, 5'd9, 32'h1, 3'b010, 2'd0, 32'h1, 1'b1, 5'd17, 32'h2);
    mon_en = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst_we", {31'h0, write_params[5]}, 32'h0);
    chk("midrst_mask", pending_mask, 32'h0);
    chk("midrst_ready", {30'h0, alu_ready, lsu_ready}, 32'h3);
`ifdef WB_FORWARD_EN
    chk("midrst_fwd", {31'h0, fwd_valid}, 32'h0);
`endif
    q.delete();
    rdy_m = 1'b1;
    @(negedge clock) reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("postrst_we", {31'h0, write_params[5]}, 32'h0);
      chk("postrst_mask", pending_mask, 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
